// File: rtl/sort_result_checker.sv
// sort_result_checker: snoops the initial dataset (key count and 64-bit sum),
// then checks the final merge output for order, count and sum, and latches a
// sticky pass/fail verdict on the first SORTDONE.
module sort_result_checker #(
    parameter int unsigned DRAMW = 128,
    parameter int unsigned KEYW  = 32,
    parameter int unsigned ELEMS = 65536,
    parameter int unsigned CNTW  = 32
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             IN_EN,
    input  logic [DRAMW-1:0] IN_DATA,
    input  logic             OUT_EN,
    input  logic [KEYW-1:0]  OUT_KEY,
    input  logic             SORTDONE,
    output logic             DONE,
    output logic             PASS,
    output logic             ERR_ORDER,
    output logic             ERR_COUNT,
    output logic             ERR_SUM,
    output logic [CNTW-1:0]  ERR_IDX,
    output logic [CNTW-1:0]  OUT_CNT
);

    localparam int unsigned KEYS = DRAMW / KEYW;
    localparam int unsigned SUMW = 64;

    typedef enum logic [1:0] {
        S_IN   = 2'd0,
        S_OUT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [SUMW-1:0]   r_in_sum;
    logic [SUMW-1:0]   r_out_sum;
    logic [CNTW-1:0]   r_in_cnt;
    logic [CNTW-1:0]   r_out_cnt;
    logic [KEYW-1:0]   r_prev;
    logic              r_done;
    logic              r_pass;
    logic              r_err_order;
    logic              r_err_count;
    logic              r_err_sum;
    logic [CNTW-1:0]   r_err_idx;

    logic [SUMW-1:0]   w_blk_sum;
    logic              w_active;
    logic              w_in_take;
    logic              w_out_take;
    logic [SUMW-1:0]   w_in_sum_eff;
    logic [SUMW-1:0]   w_out_sum_eff;
    logic [CNTW-1:0]   w_in_cnt_eff;
    logic [CNTW-1:0]   w_out_cnt_eff;
    logic              w_order_hit;
    logic              w_overflow;
    logic              w_err_order_eff;
    logic              w_err_count_eff;
    logic              w_final_count_err;
    logic              w_final_sum_err;

    // Single-cycle KEYS-way adder over the incoming block (keys zero-extended)
    always_comb begin
        w_blk_sum = '0;
        for (int unsigned i = 0; i < KEYS; i++) begin
            w_blk_sum = w_blk_sum + SUMW'(IN_DATA[KEYW*i +: KEYW]);
        end
    end

    // This cycle's effective totals, so a coincident key/block is seen by the verdict
    always_comb begin
        w_active          = (r_state != S_DONE);
        w_in_take         = (r_state == S_IN) && IN_EN;
        w_out_take        = w_active && OUT_EN;
        w_in_sum_eff      = w_in_take  ? (r_in_sum + w_blk_sum)         : r_in_sum;
        w_in_cnt_eff      = w_in_take  ? (r_in_cnt + CNTW'(KEYS))       : r_in_cnt;
        w_out_sum_eff     = w_out_take ? (r_out_sum + SUMW'(OUT_KEY))   : r_out_sum;
        w_out_cnt_eff     = w_out_take ? (r_out_cnt + CNTW'(1))         : r_out_cnt;
        w_order_hit       = w_out_take && (r_out_cnt != '0) && (OUT_KEY < r_prev) && !r_err_order;
        w_overflow        = w_out_take && (w_out_cnt_eff == CNTW'(ELEMS + 1));
        w_err_order_eff   = r_err_order | w_order_hit;
        w_err_count_eff   = r_err_count | w_overflow;
        w_final_count_err = w_err_count_eff
                          | (w_out_cnt_eff != CNTW'(ELEMS))
                          | (w_in_cnt_eff  != CNTW'(ELEMS));
        w_final_sum_err   = (w_out_sum_eff != w_in_sum_eff);
    end

    // Checker FSM: accumulate input, check output stream, latch verdict on SORTDONE
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state     <= S_IN;
            r_in_sum    <= '0;
            r_out_sum   <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_prev      <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_order <= 1'b0;
            r_err_count <= 1'b0;
            r_err_sum   <= 1'b0;
            r_err_idx   <= '0;
        end else if (w_active) begin
            r_in_sum    <= w_in_sum_eff;
            r_in_cnt    <= w_in_cnt_eff;
            r_out_sum   <= w_out_sum_eff;
            r_out_cnt   <= w_out_cnt_eff;
            r_err_order <= w_err_order_eff;
            r_err_count <= w_err_count_eff;
            if (w_out_take) begin
                r_prev <= OUT_KEY;
            end
            if (w_order_hit) begin
                r_err_idx <= r_out_cnt;
            end
            if (SORTDONE) begin
                r_state     <= S_DONE;
                r_done      <= 1'b1;
                r_err_count <= w_final_count_err;
                r_err_sum   <= w_final_sum_err;
                r_pass      <= !(w_err_order_eff | w_final_count_err | w_final_sum_err);
            end else if (w_out_take) begin
                r_state <= S_OUT;
            end
        end
    end

    assign DONE      = r_done;
    assign PASS      = r_pass;
    assign ERR_ORDER = r_err_order;
    assign ERR_COUNT = r_err_count;
    assign ERR_SUM   = r_err_sum;
    assign ERR_IDX   = r_err_idx;
    assign OUT_CNT   = r_out_cnt;

endmodule

// File: tb/tb_sort_result_checker.sv
// Testbench for sort_result_checker: directed cases plus randomized datasets,
// verdicts scored against a queue of expectations from a list-based model.
module tb_sort_result_checker;

    localparam int unsigned DRAMW = 128;
    localparam int unsigned KEYW  = 32;
    localparam int unsigned ELEMS = 8;
    localparam int unsigned CNTW  = 32;

    logic              CLK = 1'b0;
    logic              RST_X;
    logic              IN_EN;
    logic [DRAMW-1:0]  IN_DATA;
    logic              OUT_EN;
    logic [KEYW-1:0]   OUT_KEY;
    logic              SORTDONE;
    logic              DONE;
    logic              PASS;
    logic              ERR_ORDER;
    logic              ERR_COUNT;
    logic              ERR_SUM;
    logic [CNTW-1:0]   ERR_IDX;
    logic [CNTW-1:0]   OUT_CNT;

    always #5 CLK = ~CLK;

    sort_result_checker #(
        .DRAMW(DRAMW), .KEYW(KEYW), .ELEMS(ELEMS), .CNTW(CNTW)
    ) dut (
        .CLK(CLK), .RST_X(RST_X), .IN_EN(IN_EN), .IN_DATA(IN_DATA),
        .OUT_EN(OUT_EN), .OUT_KEY(OUT_KEY), .SORTDONE(SORTDONE),
        .DONE(DONE), .PASS(PASS), .ERR_ORDER(ERR_ORDER), .ERR_COUNT(ERR_COUNT),
        .ERR_SUM(ERR_SUM), .ERR_IDX(ERR_IDX), .OUT_CNT(OUT_CNT)
    );

    typedef struct {
        bit          pass;
        bit          eo;
        bit          ec;
        bit          es;
        logic [31:0] idx;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] g_in[$];
    logic [31:0] g_out[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          done_prev = 1'b0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference verdict computed directly from the key lists
    function automatic exp_t model();
        exp_t        e;
        logic [63:0] si = '0;
        logic [63:0] so = '0;
        foreach (g_in[i])  si = si + 64'(g_in[i]);
        foreach (g_out[i]) so = so + 64'(g_out[i]);
        e.eo  = 1'b0;
        e.idx = '0;
        for (int i = 1; i < g_out.size(); i++) begin
            if (!e.eo && g_out[i] < g_out[i-1]) begin
                e.eo  = 1'b1;
                e.idx = 32'(i);
            end
        end
        e.ec   = (g_out.size() != int'(ELEMS)) || (g_in.size() != int'(ELEMS));
        e.es   = (si != so);
        e.pass = !(e.eo || e.ec || e.es);
        e.cnt  = 32'(g_out.size());
        return e;
    endfunction

    // Flags expected after the first n output keys, before any verdict
    task automatic check_prefix(input int n);
        bit          eo  = 1'b0;
        logic [31:0] idx = '0;
        for (int i = 1; i < n; i++) begin
            if (!eo && g_out[i] < g_out[i-1]) begin
                eo  = 1'b1;
                idx = 32'(i);
            end
        end
        check($sformatf("prefix_%0d", n),
              {1'b0, DONE, ERR_ORDER, ERR_COUNT, ERR_IDX, OUT_CNT},
              {1'b0, 1'b0, eo, (n > int'(ELEMS)), idx, 32'(n)});
    endtask

    function automatic logic [68:0] outs_now();
        return {DONE, PASS, ERR_ORDER, ERR_COUNT, ERR_SUM, ERR_IDX, OUT_CNT};
    endfunction

    task automatic reset_dut();
        RST_X    = 1'b0;
        IN_EN    = 1'b0;
        OUT_EN   = 1'b0;
        SORTDONE = 1'b0;
        IN_DATA  = '0;
        OUT_KEY  = '0;
        #1;
        check("reset_clear", 80'(outs_now()), 80'(0));
        @(negedge CLK);
        RST_X = 1'b1;
    endtask

    task automatic fill_seq(input int n);
        g_in.delete();
        g_out.delete();
        for (int i = 1; i <= int'(ELEMS); i++) g_in.push_back(32'(i));
        for (int i = 1; i <= n; i++) g_out.push_back(32'(i));
    endtask

    // Drive one dataset and output stream; expectation pushed at issue time
    task automatic run_case(input bit sd_with_last, input bit overlap);
        exp_t e;
        int   nblk;
        int   nout;
        int   start;
        int   total;
        int   k;
        e = model();
        sb.push_back(e);
        nblk  = g_in.size() / 4;
        nout  = g_out.size();
        start = (overlap && nblk > 0) ? nblk - 1 : nblk;
        total = (start + nout > nblk) ? start + nout : nblk;
        for (int c = 0; c < total; c++) begin
            @(negedge CLK);
            if (c - 1 >= start && c - 1 < start + nout) check_prefix(c - start);
            IN_EN = (c < nblk);
            if (c < nblk) IN_DATA = {g_in[4*c+3], g_in[4*c+2], g_in[4*c+1], g_in[4*c]};
            k = c - start;
            OUT_EN = (k >= 0 && k < nout);
            if (OUT_EN) OUT_KEY = g_out[k];
            SORTDONE = sd_with_last && (nout > 0) && (k == nout - 1);
        end
        @(negedge CLK);
        IN_EN  = 1'b0;
        OUT_EN = 1'b0;
        if (SORTDONE) begin
            SORTDONE = 1'b0;
            check("cnt_coincident", 80'(OUT_CNT), 80'(nout));
        end else begin
            if (nout > 0) check_prefix(nout);
            SORTDONE = 1'b1;
            @(negedge CLK);
            SORTDONE = 1'b0;
        end
        repeat (3) @(negedge CLK);
        check("verdict_seen", 80'(sb.size()), 80'(0));
        IN_EN    = 1'b1;
        IN_DATA  = {$urandom, $urandom, $urandom, $urandom};
        OUT_EN   = 1'b1;
        OUT_KEY  = '0;
        SORTDONE = 1'b1;
        @(negedge CLK);
        IN_EN    = 1'b0;
        OUT_EN   = 1'b0;
        SORTDONE = 1'b0;
        check("hold_after_done", 80'(outs_now()),
              80'({1'b1, e.pass, e.eo, e.ec, e.es, e.idx, e.cnt}));
    endtask

    // Monitor: compare each new verdict against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (DONE && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 80'(1), 80'(0));
                end else begin
                    e = sb.pop_front();
                    check("verdict", 80'(outs_now()),
                          80'({1'b1, e.pass, e.eo, e.ec, e.es, e.idx, e.cnt}));
                end
            end
            done_prev = DONE;
        end
    end

    initial begin
        logic [31:0] keys[$];
        int          mode;
        int          j;
        logic [31:0] t;

        reset_dut();

        fill_seq(8);
        run_case(1'b0, 1'b0);

        reset_dut();
        fill_seq(0);
        g_out = '{32'd1, 32'd2, 32'd5, 32'd3, 32'd4, 32'd6, 32'd7, 32'd8};
        run_case(1'b0, 1'b0);

        reset_dut();
        fill_seq(7);
        run_case(1'b0, 1'b0);

        reset_dut();
        fill_seq(9);
        run_case(1'b0, 1'b0);

        reset_dut();
        fill_seq(7);
        g_out.push_back(32'd9);
        run_case(1'b0, 1'b0);

        reset_dut();
        g_in.delete();
        g_out.delete();
        for (int i = 0; i < 8; i++) begin
            g_in.push_back(32'hFFFF_FFFF);
            g_out.push_back(32'hFFFF_FFFF);
        end
        run_case(1'b1, 1'b0);

        // Reset in the middle of the output phase, then a clean rerun
        reset_dut();
        fill_seq(8);
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            IN_EN  = (c < 2);
            if (c < 2) IN_DATA = {g_in[4*c+3], g_in[4*c+2], g_in[4*c+1], g_in[4*c]};
            OUT_EN = (c >= 2);
            if (c >= 2) OUT_KEY = g_out[c-2];
        end
        @(negedge CLK);
        OUT_EN = 1'b0;
        check("midrun_cnt", 80'(OUT_CNT), 80'(4));
        reset_dut();
        run_case(1'b0, 1'b1);

        // Randomized datasets with optional perturbation of the output stream
        for (int r = 0; r < 24; r++) begin
            reset_dut();
            keys.delete();
            for (int i = 0; i < 8; i++)
                keys.push_back((r % 2 == 0) ? $urandom : $urandom_range(0, 15));
            g_in  = keys;
            g_out = keys;
            g_out.sort();
            mode = $urandom_range(0, 4);
            j    = $urandom_range(0, 6);
            case (mode)
                1: begin t = g_out[j]; g_out[j] = g_out[j+1]; g_out[j+1] = t; end
                2: g_out[j] = g_out[j] + 32'd1;
                3: void'(g_out.pop_back());
                4: g_out.push_back($urandom);
                default: ;
            endcase
            run_case(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sort_result_checker.md
# sort_result_checker

Simulation and on-chip self-check stage for the FPGA sorter, placed directly downstream of the core's final merge output. It does two things:
- Snoops the initial dataset as it is written to DRAM, accumulating a key count and a 64-bit key sum.
- Consumes the last-phase output stream one key per cycle, checking non-decreasing order, count and sum against the input side.

It reports a sticky pass/fail verdict once the core signals sort completion, replacing manual inspection of the last-phase dump.

## Interface
Parameters:
- DRAMW, 128: DRAM block width in bits; must be a multiple of KEYW.
- KEYW, 32: key width in bits (unsigned). KEYS = DRAMW/KEYW keys per block.
- ELEMS, 65536: expected total key count; must be ≥ 1 and a multiple of KEYS.
- CNTW, 32: width of counters and index outputs.

Ports:
- CLK  in  1  system clock; all state is updated on the rising edge.
- RST_X  in  1  asynchronous, active-low reset.
- IN_EN  in  1  one initial-data block is valid on IN_DATA this cycle.
- IN_DATA  in  DRAMW  initial-data block; key i is bits [KEYW*i +: KEYW].
- OUT_EN  in  1  one sorted key is valid on OUT_KEY this cycle (last-phase dequeue).
- OUT_KEY  in  KEYW  sorted key.
- SORTDONE  in  1  core completion pulse; only the first assertion is acted on.
- DONE  out  1  verdict valid; sticky.
- PASS  out  1  DONE with no error flags set; sticky.
- ERR_ORDER  out  1  a key was smaller than its predecessor.
- ERR_COUNT  out  1  input or output key count is not ELEMS.
- ERR_SUM  out  1  output key sum is not equal to input key sum.
- ERR_IDX  out  CNTW  0-based output index of the first out-of-order key.
- OUT_CNT  out  CNTW  number of output keys accepted so far.

## Operation
- Internal state:
  - in_sum, out_sum: 64 bits, arithmetic modulo 2^64, keys zero-extended.
  - in_cnt, out_cnt: CNTW bits each.
  - prev: KEYW-bit register holding the previous output key.
- The FSM has three states: S_IN, S_OUT and S_DONE.
- S_IN (entered on reset):
  - IN_EN: in_sum += sum of all KEYS keys in the block; in_cnt += KEYS.
  - The first OUT_EN moves the FSM to S_OUT, and that key is processed exactly as in S_OUT in the same cycle.
  - If IN_EN and OUT_EN are asserted together, both are accepted.
- S_OUT:
  - IN_EN is ignored.
  - Each OUT_EN: out_sum += OUT_KEY; out_cnt += 1; prev <= OUT_KEY.
  - If out_cnt > 0, OUT_KEY < prev (unsigned compare) and ERR_ORDER = 0: set ERR_ORDER and set ERR_IDX = out_cnt (pre-increment value). Later violations do not update ERR_IDX.
  - Equal keys are legal.
  - out_cnt reaching ELEMS+1: set ERR_COUNT immediately; keys continue to be counted and summed.
- SORTDONE, in S_IN or S_OUT:
  - Move to S_DONE.
  - A coincident OUT_EN key is included before evaluation.
  - ERR_COUNT |= (final out_cnt ≠ ELEMS) or (in_cnt ≠ ELEMS).
  - ERR_SUM = (final out_sum ≠ in_sum).
  - DONE = 1; PASS = no error flag set.
  - SORTDONE in S_IN means no output was seen, so ERR_COUNT is set.
- S_DONE:
  - Absorbing state; all inputs are ignored.
  - All outputs hold until RST_X is asserted.
- Counters wrap at 2^CNTW with no saturation. ELEMS must be below 2^CNTW.

## Timing
- Reset: RST_X low immediately clears all outputs and internal state to 0 and puts the FSM in S_IN, including in the middle of a run.
- All outputs are registered.
- OUT_CNT updates in the cycle after the OUT_EN edge.
- ERR_ORDER, ERR_IDX and the overflow ERR_COUNT rise in the cycle after the offending OUT_EN.
- DONE, PASS, ERR_SUM and the final ERR_COUNT rise in the cycle after SORTDONE is sampled, i.e. 1-cycle latency.
- No back-pressure: every IN_EN and OUT_EN is consumed in the cycle it is asserted. Throughput is 1 block plus 1 key per cycle.
- Sum path: the KEYS-way adder for IN_DATA completes in a single cycle. A pipelined adder is not permitted because it would lose a block coincident with the S_IN→S_OUT transition.

## Test plan
- Pass case (DRAMW=128, KEYW=32, ELEMS=8):
  - Stimulus: IN blocks {1,2,3,4} and {5,6,7,8}; OUT keys 1..8 on consecutive cycles; SORTDONE one cycle after the last key.
  - Required: DONE=1, PASS=1, OUT_CNT=8, all ERR flags 0.
- Order error:
  - Stimulus: OUT keys 1,2,5,3,4,6,7,8.
  - Required: ERR_ORDER=1 the cycle after key 3; ERR_IDX=3; ERR_SUM=0; ERR_COUNT=0; PASS=0 after SORTDONE.
- Count errors:
  - 7 output keys then SORTDONE → ERR_COUNT=1, PASS=0.
  - 9 output keys → ERR_COUNT rises the cycle after the 9th key, before SORTDONE.
- Sum error:
  - Stimulus: OUT keys 1..7,9 (ordered, correct count).
  - Required: ERR_SUM=1 only; ERR_ORDER=0; ERR_COUNT=0.
- Edge values:
  - Stimulus: input of eight 0xFFFFFFFF keys, output the same eight keys, with SORTDONE coincident with the 8th OUT_EN.
  - Required: PASS=1 and OUT_CNT=8. The sum 0x7_FFFFFFF8 is carried correctly beyond 32 bits, and duplicate keys raise no ERR_ORDER.
- Mid-run reset:
  - Stimulus: RST_X low during S_OUT after 4 keys.
  - Required: all outputs read 0 immediately; a full pass-case rerun afterwards yields PASS=1.
